// File: rtl/ebus_arbiter.sv
// EBUS arbiter between the EBOX (via CON) and the PI function-cycle logic.
// Optional EBOX tenure watchdog is compiled in with `define EBUS_ARB_TIMEOUT_EN.
module ebus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ebox_req,
    input  logic con_ebus_rel,
    input  logic pi_req,
    input  logic pi_done,
    output logic con_ebus_grant,
    output logic pi_ebus_grant,
    output logic ebus_busy,
    output logic ebus_timeout
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PI_OWN   = 2'd1,
        S_EBOX_OWN = 2'd2,
        S_TURN     = 2'd3
    } state_t;

    // Counter must be able to represent TIMEOUT_CYCLES-1.
    generate
        if ((64'(1) << CNT_W) <= 64'(TIMEOUT_CYCLES) || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
            $error("ebus_arbiter: need 0 < TIMEOUT_CYCLES < 2**CNT_W");
        end
    endgenerate

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last_pi;
    logic   w_timeout_c;
    logic   r_con_grant;
    logic   r_pi_grant;
    logic   r_busy;
    logic   r_timeout;

`ifdef EBUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_expired;

    // Tenure counter: zero on the first EBOX_OWN cycle, +1 per owned cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state != S_EBOX_OWN) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_cnt_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state and timeout decision.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout_c = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (pi_req && !(r_last_pi && ebox_req)) begin
                    w_state_nxt = S_PI_OWN;
                end else if (ebox_req) begin
                    w_state_nxt = S_EBOX_OWN;
                end
            end
            S_PI_OWN: begin
                if (pi_done) begin
                    w_state_nxt = S_TURN;
                end
            end
            S_EBOX_OWN: begin
                if (con_ebus_rel) begin
                    w_state_nxt = S_TURN;
`ifdef EBUS_ARB_TIMEOUT_EN
                end else if (w_cnt_expired) begin
                    w_state_nxt = S_TURN;
                    w_timeout_c = 1'b1;
`endif
                end
            end
            S_TURN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, fairness bit and outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last_pi   <= 1'b0;
            r_con_grant <= 1'b0;
            r_pi_grant  <= 1'b0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_con_grant <= (w_state_nxt == S_EBOX_OWN);
            r_pi_grant  <= (w_state_nxt == S_PI_OWN);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_timeout   <= w_timeout_c;
            if (w_state_nxt == S_PI_OWN) begin
                r_last_pi <= 1'b1;
            end else if (w_state_nxt == S_EBOX_OWN) begin
                r_last_pi <= 1'b0;
            end
        end
    end

    assign con_ebus_grant = r_con_grant;
    assign pi_ebus_grant  = r_pi_grant;
    assign ebus_busy      = r_busy;
    assign ebus_timeout   = r_timeout;

endmodule

// File: tb/tb_ebus_arbiter.sv
// Self-checking bench for ebus_arbiter: directed steps plus random traffic
// against an ownership-level reference model.
module tb_ebus_arbiter;

    localparam int unsigned TIMEOUT = 8;
`ifdef EBUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic ebox_req, con_ebus_rel, pi_req, pi_done;
    logic con_ebus_grant, pi_ebus_grant, ebus_busy, ebus_timeout;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who holds the bus, whether the release gap is running,
    // who held it last, and how many cycles the EBOX has held it.
    localparam int NOBODY = 0, PI = 1, EBOX = 2;
    int m_owner  = NOBODY;
    bit m_gap    = 1'b0;
    bit m_prevpi = 1'b0;
    bit m_to     = 1'b0;
    int m_tenure = 0;

    ebus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ebox_req       (ebox_req),
        .con_ebus_rel   (con_ebus_rel),
        .pi_req         (pi_req),
        .pi_done        (pi_done),
        .con_ebus_grant (con_ebus_grant),
        .pi_ebus_grant  (pi_ebus_grant),
        .ebus_busy      (ebus_busy),
        .ebus_timeout   (ebus_timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner  = NOBODY;
        m_gap    = 1'b0;
        m_prevpi = 1'b0;
        m_to     = 1'b0;
        m_tenure = 0;
    endtask

    task automatic model_step();
        m_to = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner == PI) begin
            if (pi_done) begin
                m_owner = NOBODY;
                m_gap   = 1'b1;
            end
        end else if (m_owner == EBOX) begin
            m_tenure++;
            if (con_ebus_rel) begin
                m_owner = NOBODY;
                m_gap   = 1'b1;
            end else if (TO_EN && m_tenure == int'(TIMEOUT)) begin
                m_owner = NOBODY;
                m_gap   = 1'b1;
                m_to    = 1'b1;
            end
        end else if (pi_req && (!ebox_req || !m_prevpi)) begin
            m_owner  = PI;
            m_prevpi = 1'b1;
        end else if (ebox_req) begin
            m_owner  = EBOX;
            m_prevpi = 1'b0;
            m_tenure = 0;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":pi_grant"},  pi_ebus_grant,  logic'(m_owner == PI));
        chk({tag, ":con_grant"}, con_ebus_grant, logic'(m_owner == EBOX));
        chk({tag, ":busy"},      ebus_busy,      logic'(m_owner != NOBODY || m_gap));
        chk({tag, ":timeout"},   ebus_timeout,   logic'(m_to));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic pulse_rel(input string tag);
        con_ebus_rel = 1'b1;
        tick(tag);
        con_ebus_rel = 1'b0;
    endtask

    task automatic pulse_done(input string tag);
        pi_done = 1'b1;
        tick(tag);
        pi_done = 1'b0;
    endtask

    initial begin
        // Reset held with every input high: outputs stay low.
        rst_n = 1'b0; ebox_req = 1'b1; pi_req = 1'b1; con_ebus_rel = 1'b1; pi_done = 1'b1;
        #2;
        check_all("reset_async");
        ticks("reset_hold", 3);

        // Release with only the EBOX requesting: grant one cycle later.
        pi_req = 1'b0; con_ebus_rel = 1'b0; pi_done = 1'b0; rst_n = 1'b1;
        tick("ebox_first");
        chk("ebox_latency", con_ebus_grant, 1'b1);

        // Dropping the request does not release the bus.
        ebox_req = 1'b0;
        ticks("req_drop_hold", 3);
        pulse_rel("req_drop_rel");
        ticks("req_drop_gap", 2);

        // Contention from reset: P first, then alternation P,E,P,E.
        rst_n = 1'b0; pi_req = 1'b1; ebox_req = 1'b1;
        tick("cont_reset");
        rst_n = 1'b1;
        tick("cont_p1");
        chk("cont_pi_first", pi_ebus_grant, 1'b1);
        pulse_rel("stray_rel_pi");
        ticks("pi_hold", 2);
        pulse_done("p1_done");
        ticks("cont_gap1", 2);
        chk("cont_ebox_second", con_ebus_grant, 1'b1);
        ticks("e1_hold", 2);
        pulse_rel("e1_rel");
        ticks("cont_gap2", 2);
        chk("cont_pi_third", pi_ebus_grant, 1'b1);
        pulse_done("p2_done");
        ticks("cont_gap3", 2);
        chk("cont_ebox_fourth", con_ebus_grant, 1'b1);
        pulse_done("stray_done_ebox");
        pi_req = 1'b0; ebox_req = 1'b0;
        pulse_rel("e2_rel");
        ticks("to_idle", 2);

        // Stray pulses in IDLE.
        pulse_rel("stray_rel_idle");
        pulse_done("stray_done_idle");
        tick("idle_quiet");

        // One-cycle tenure.
        ebox_req = 1'b1;
        tick("one_cyc_grant");
        ebox_req = 1'b0;
        pulse_rel("one_cyc_rel");
        chk("one_cyc_dropped", con_ebus_grant, 1'b0);
        ticks("one_cyc_gap", 2);

        // Asynchronous reset mid-tenure drops the grant at once.
        pi_req = 1'b1;
        tick("async_grant");
        pi_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_drop");
        tick("async_hold");
        rst_n = 1'b1;
        tick("async_release");

        // Long EBOX tenure: watchdog behaviour or unbounded hold.
        ebox_req = 1'b1;
        if (TO_EN) begin
            ticks("wd_expire", TIMEOUT + 3);
            tick("wd_regrant");
            ticks("wd_rel_hold", TIMEOUT - 1);
            pulse_rel("wd_rel_last");
            ebox_req = 1'b0;
            ticks("wd_rel_gap", 3);
        end else begin
            ticks("hold_5000", 5000);
            chk("hold_5000_grant", con_ebus_grant, 1'b1);
            ebox_req = 1'b0;
            pulse_rel("hold_rel");
            ticks("hold_gap", 2);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(99) != 0);
            ebox_req     = 1'($urandom_range(1));
            pi_req       = 1'($urandom_range(1));
            con_ebus_rel = ($urandom_range(3) == 0);
            pi_done      = ($urandom_range(3) == 0);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ebus_arbiter.md
# ebus_arbiter

Owns the EBUS between the EBOX (via CON) and the PI function-cycle logic. Accepts the EBOX's bus request and PI's function-cycle request, issues exactly one grant at a time, and enforces a one-cycle turnaround after every release. CON's EBUS_GRANT is driven from this block, and CON's EBUS_REL is consumed here. An optional watchdog reclaims the bus from a hung EBOX tenure.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1024: EBOX tenure limit in clocks; only used when the watchdog is compiled in.
- CNT_W, default 11: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ebox_req  in  1  EBOX wants the EBUS; level, held until granted.
- con_ebus_rel  in  1  CON EBUS_REL; one-cycle pulse ending the EBOX tenure.
- pi_req  in  1  PI function cycle wants the EBUS; level.
- pi_done  in  1  PI function cycle complete; one-cycle pulse.
- con_ebus_grant  out  1  CON EBUS_GRANT; EBOX owns the bus.
- pi_ebus_grant  out  1  PI owns the bus.
- ebus_busy  out  1  any grant active or in turnaround.
- ebus_timeout  out  1  one-cycle pulse when the watchdog reclaims the bus.

## Operation
- Four states: IDLE, PI_OWN, EBOX_OWN, TURN.
- IDLE: if pi_req and not (last_pi and ebox_req), go to PI_OWN. Else if ebox_req, go to EBOX_OWN. Otherwise stay in IDLE.
- last_pi records the most recent owner. It is set on entry to PI_OWN and cleared on entry to EBOX_OWN.
- Arbitration result: PI wins ties unless PI held the previous tenure and the EBOX is waiting. This alternates ownership under contention, so neither side starves.
- PI_OWN: pi_ebus_grant=1. On pi_done, go to TURN.
- EBOX_OWN: con_ebus_grant=1. On con_ebus_rel, go to TURN.
- Dropping ebox_req or pi_req while owning does not release the bus; only rel/done does.
- TURN: both grants 0, ebus_busy=1. Lasts exactly one cycle, then IDLE.
- Stray pulses: con_ebus_rel outside EBOX_OWN is ignored. pi_done outside PI_OWN is ignored. Neither causes an error.
- Outputs are decoded directly from registered state; there are no combinational paths from inputs to outputs.
- ebus_busy = state != IDLE.
- Grants are mutually exclusive in every cycle.

## Timing
- Reset: state=IDLE, last_pi=0, counter=0, all outputs 0. Assertion of rst_n mid-tenure drops the grant asynchronously.
- Request latency: a request sampled in IDLE at edge N produces its grant after edge N, i.e. it is visible in cycle N+1.
- Release latency:
  - rel/done sampled at edge M: the grant is low from cycle M+1 (TURN).
  - IDLE in cycle M+2.
  - Earliest next grant in cycle M+3.
- Back-to-back contention yields the pattern: grant A, TURN, IDLE, grant B.
- Minimum tenure is one cycle: rel/done may arrive in the first granted cycle.

## Configuration
- EBUS_ARB_TIMEOUT_EN defined:
  - A CNT_W counter clears on entry to EBOX_OWN and increments each EBOX_OWN cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no con_ebus_rel, the block goes to TURN and pulses ebus_timeout for one cycle, coincident with the grant dropping.
  - con_ebus_rel on that same edge takes precedence: normal release, no timeout pulse.
- EBUS_ARB_TIMEOUT_EN not defined:
  - No counter is built, and ebus_timeout is tied 0.
  - EBOX tenure is unbounded.

## Test plan
- Reset: hold rst_n=0 with all requests high -> every output stays 0. Release reset with ebox_req=1 -> con_ebus_grant=1 one cycle later.
- Simultaneous first requests, then persistent contention:
  - pi_req=ebox_req=1 from reset -> PI is granted first.
  - pi_done -> one TURN cycle, IDLE -> EBOX is granted.
  - con_ebus_rel -> TURN, IDLE -> PI is granted.
  - Grant order is P,E,P,E with exactly 2 ungranted cycles between tenures.
- Stray releases: pulse con_ebus_rel in IDLE and during PI_OWN -> no state change, and pi_ebus_grant stays 1 until pi_done.
- Request drop: ebox_req falls while con_ebus_grant=1 -> the grant holds until con_ebus_rel. One-cycle tenure: rel in the first granted cycle -> grant is high for exactly 1 cycle.
- Watchdog, with EBUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8:
  - EBOX granted with no release -> grant is high for 8 cycles, then ebus_timeout pulses once and the block passes through TURN to IDLE.
  - Repeat with rel on cycle 8 -> no timeout pulse.
- Watchdog compiled out: hold the EBOX grant for 5000 cycles -> the grant persists and ebus_timeout stays 0.
